apb_master: RTL and testbench
=============================

APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, 255, the maximum number of ACCESS cycles waited for PREADY (range 1..255).
REQ-002 The block SHALL have port PCLK  input  1  the single clock; all state updates on rising edge.
REQ-003 The block SHALL have port PRESET  input  1  asynchronous, active-high reset.
REQ-004 The block SHALL have port transfer  input  1  CPU request strobe.
REQ-005 The block SHALL have port addr  input  32  CPU byte address.
REQ-006 The block SHALL have port wdata  input  32  CPU write data.
REQ-007 The block SHALL have port write  input  1  1=write, 0=read.
REQ-008 The block SHALL have port rdata  output  32  read data returned to the CPU.
REQ-009 The block SHALL have port ready  output  1  one-cycle transfer-complete pulse.
REQ-010 The block SHALL have port error  output  1  qualifies ready; 1=timeout or unmapped address.
REQ-011 The block SHALL have port PADDR  output  32  APB address.
REQ-012 The block SHALL have port PWDATA  output  32  APB write data.
REQ-013 The block SHALL have port PWRITE  output  1  APB direction.
REQ-014 The block SHALL have port PENABLE  output  1  APB access phase.
REQ-015 The block SHALL have ports PSEL0..PSEL4  output  1 each  slave selects.
REQ-016 The block SHALL have ports PRDATA0..PRDATA4  input  32 each  and PREADY0..PREADY4  input  1 each  slave responses.

Function
REQ-017 The block SHALL implement FSM states IDLE, SETUP and ACCESS.
REQ-018 IDLE, transfer=1: the block SHALL register addr/wdata/write into PADDR/PWDATA/PWRITE and go to SETUP on the next edge.
REQ-019 SETUP: selected PSELn=1 and PENABLE=0, for exactly one cycle; the next state SHALL be ACCESS.
REQ-020 ACCESS: selected PSELn=1 and PENABLE=1; the block SHALL remain in ACCESS while the selected PREADYn=0.
REQ-021 Address decode SHALL use PADDR[31:12]: 0x10000->PSEL0, 0x10001->PSEL1, 0x10002->PSEL2, 0x10003->PSEL3, 0x10004->PSEL4; at most one PSELn SHALL be high at a time.
REQ-022 Any other PADDR[31:12] (unmapped) SHALL drive no PSELn; in ACCESS the block SHALL complete immediately with ready=1, error=1, rdata=0.
REQ-023 PSELn/PENABLE SHALL be decoded from the state register and the registered PADDR only; all PSELn SHALL be 0 in IDLE.
REQ-024 Completion occurs in the ACCESS cycle where the selected PREADYn=1: ready=1, error=0, rdata=selected PRDATAn, all combinational in that same cycle.
REQ-025 rdata SHALL be 0 in every cycle where ready=0, and on write completions.
REQ-026 A wait counter SHALL clear on entry to ACCESS and increment each ACCESS cycle without PREADY.
REQ-027 When the wait counter reaches TIMEOUT without PREADY, the block SHALL complete with ready=1, error=1, rdata=0 and leave ACCESS.
REQ-028 In the completion cycle, transfer=1 SHALL latch the new request and go directly to SETUP (back-to-back); otherwise the next state SHALL be IDLE.
REQ-029 transfer SHALL be ignored in SETUP and in non-completing ACCESS cycles; addr/wdata/write changes there SHALL not affect PADDR/PWDATA/PWRITE.
REQ-030 PADDR/PWDATA/PWRITE SHALL hold stable from SETUP through the completion cycle.
REQ-031 Minimum latency SHALL be: transfer sampled at edge N, SETUP in cycle N+1, earliest ready in cycle N+2.

Reset
REQ-032 While PRESET=1, the block SHALL hold state IDLE; PADDR=0, PWDATA=0, PWRITE=0, PENABLE=0, all PSELn=0, ready=0, error=0, rdata=0, wait counter=0, effective immediately (asynchronous).
REQ-033 PRESET asserted mid-transfer SHALL abort it with no ready pulse; the first transfer after release SHALL start from IDLE.

Verification
REQ-034 Write addr=0x1000_2008, wdata=0xA5 with a slave whose PREADY is registered (one wait) -> PSEL2 for 3 cycles, PENABLE for 2 cycles, ready=1 and error=0 in the 2nd ACCESS cycle.
REQ-035 Read addr=0x1000_1004 with PRDATA1=0x0000_00C3 and zero-wait PREADY -> ready in cycle N+2, rdata=0xC3, PWRITE=0.
REQ-036 Back-to-back: transfer held high across a completion to 0x1000_0000 then 0x1000_3000 -> SETUP immediately follows completion; PSEL0 then PSEL3; no IDLE cycle between.
REQ-037 Unmapped addr=0x2000_0000 -> no PSELn asserted, ready=1 and error=1 in the ACCESS cycle, rdata=0.
REQ-038 TIMEOUT=4 with PREADY4 stuck at 0 on addr 0x1000_4000 -> ready=1, error=1 after 4 ACCESS cycles, then IDLE.
REQ-039 PRESET pulsed during ACCESS -> PSEL/PENABLE drop to 0 asynchronously, no ready pulse, next transfer completes normally.

Source files
------------

// File: rtl/apb_master.sv
// APB bridge: turns one CPU request into an APB SETUP/ACCESS transfer
// on one of five decoded slaves, with a bounded wait for PREADY.
module apb_master #(
    parameter int TIMEOUT = 255
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        transfer,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic        write,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        error,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    output logic        PSEL4,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic [31:0] PRDATA4,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3,
    input  logic        PREADY4
);

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS} state_t;

    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    state_t      state, next;
    logic [7:0]  wait_cnt;
    logic [19:0] page;
    logic [2:0]  idx;
    logic        mapped;
    logic [4:0]  psel;
    logic        sel_ready;
    logic [31:0] sel_rdata;
    logic        done;
    logic        load;

    assign page   = PADDR[31:12];
    assign idx    = page[2:0];
    assign mapped = (page >= 20'h10000) && (page <= 20'h10004);

    always_comb begin
        sel_ready = 1'b0;
        sel_rdata = 32'h0;
        case (idx)
            3'd0: begin sel_ready = PREADY0; sel_rdata = PRDATA0; end
            3'd1: begin sel_ready = PREADY1; sel_rdata = PRDATA1; end
            3'd2: begin sel_ready = PREADY2; sel_rdata = PRDATA2; end
            3'd3: begin sel_ready = PREADY3; sel_rdata = PRDATA3; end
            3'd4: begin sel_ready = PREADY4; sel_rdata = PRDATA4; end
            default: begin sel_ready = 1'b0; sel_rdata = 32'h0; end
        endcase
        if (!mapped) begin
            sel_ready = 1'b0;
            sel_rdata = 32'h0;
        end
    end

    assign psel = (state != IDLE && mapped) ? (5'd1 << idx) : 5'd0;
    assign {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0} = psel;
    assign PENABLE = (state == ACCESS);

    // Unmapped pages finish at once; mapped ones on PREADY or timeout.
    assign done  = (state == ACCESS) &&
                   (!mapped || sel_ready || wait_cnt == LAST);
    assign ready = done;
    assign error = done && !sel_ready;
    assign rdata = (done && sel_ready && !PWRITE) ? sel_rdata : 32'h0;

    always_comb begin
        next = state;
        load = 1'b0;
        unique case (state)
            IDLE: begin
                if (transfer) begin
                    next = SETUP;
                    load = 1'b1;
                end
            end
            SETUP: next = ACCESS;
            ACCESS: begin
                if (done) begin
                    if (transfer) begin
                        next = SETUP;
                        load = 1'b1;
                    end else begin
                        next = IDLE;
                    end
                end
            end
            default: next = IDLE;
        endcase
    end

    always_ff @(posedge PCLK or posedge PRESET) begin
        if (PRESET) begin
            state    <= IDLE;
            wait_cnt <= 8'd0;
            PADDR    <= 32'h0;
            PWDATA   <= 32'h0;
            PWRITE   <= 1'b0;
        end else begin
            state <= next;
            if (state == SETUP)
                wait_cnt <= 8'd0;
            else if (state == ACCESS && !done)
                wait_cnt <= wait_cnt + 8'd1;
            if (load) begin
                PADDR  <= addr;
                PWDATA <= wdata;
                PWRITE <= write;
            end
        end
    end

endmodule

// File: tb/tb_apb_master.sv
// Bench for apb_master: transaction-level model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_apb_master;

    localparam int TO = 4;

    logic        PCLK = 1'b0;
    logic        PRESET = 1'b1;
    logic        transfer = 1'b0;
    logic        write = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        ready, error, PWRITE, PENABLE;
    logic        PSEL0, PSEL1, PSEL2, PSEL3, PSEL4;
    logic [4:0]  psel_v;
    logic [4:0]  pready_v;
    logic [31:0] prdata_v [5];
    int          wait_cfg [5];
    int          acnt [5];

    int n_chk = 0;
    int n_fail = 0;

    always #5 PCLK = ~PCLK;

    apb_master #(.TIMEOUT(TO)) dut (
        .PCLK(PCLK), .PRESET(PRESET), .transfer(transfer),
        .addr(addr), .wdata(wdata), .write(write),
        .rdata(rdata), .ready(ready), .error(error),
        .PADDR(PADDR), .PWDATA(PWDATA), .PWRITE(PWRITE),
        .PENABLE(PENABLE),
        .PSEL0(PSEL0), .PSEL1(PSEL1), .PSEL2(PSEL2),
        .PSEL3(PSEL3), .PSEL4(PSEL4),
        .PRDATA0(prdata_v[0]), .PRDATA1(prdata_v[1]),
        .PRDATA2(prdata_v[2]), .PRDATA3(prdata_v[3]),
        .PRDATA4(prdata_v[4]),
        .PREADY0(pready_v[0]), .PREADY1(pready_v[1]),
        .PREADY2(pready_v[2]), .PREADY3(pready_v[3]),
        .PREADY4(pready_v[4])
    );

    assign psel_v = {PSEL4, PSEL3, PSEL2, PSEL1, PSEL0};

    // Slave n inserts wait_cfg[n] wait states per access.
    always_comb begin
        for (int n = 0; n < 5; n++)
            pready_v[n] = psel_v[n] && PENABLE && (acnt[n] >= wait_cfg[n]);
    end

    always @(posedge PCLK) begin
        for (int n = 0; n < 5; n++)
            acnt[n] <= (psel_v[n] && PENABLE && !pready_v[n]) ? acnt[n] + 1 : 0;
    end

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", nm, act, exp);
        end
    endtask

    // Transaction model: phase 0 is the setup cycle, phase k>=1 the k-th
    // access cycle; a transfer ends on PREADY, unmapped page, or TO cycles.
    logic        m_busy;
    logic [31:0] m_addr, m_wdata;
    logic        m_write;
    int          m_phase;

    always @(negedge PCLK) begin
        logic        mapped, sel_rdy, e_ready, e_err, e_pen;
        logic [4:0]  e_sel;
        logic [31:0] e_rd;
        int          idx;
        if (PRESET) begin
            m_busy = 1'b0; m_addr = 32'h0; m_wdata = 32'h0;
            m_write = 1'b0; m_phase = 0;
        end
        mapped  = (m_addr[31:12] >= 20'h10000) && (m_addr[31:12] <= 20'h10004);
        idx     = mapped ? int'(m_addr[31:12] - 20'h10000) : 0;
        sel_rdy = mapped && pready_v[idx];
        e_sel   = (m_busy && mapped) ? 5'(1 << idx) : 5'd0;
        e_pen   = m_busy && (m_phase >= 1);
        e_ready = e_pen && (!mapped || sel_rdy || m_phase == TO);
        e_err   = e_ready && !sel_rdy;
        e_rd    = (e_ready && !e_err && !m_write) ? prdata_v[idx] : 32'h0;
        chk("m_psel", 32'(psel_v), 32'(e_sel));
        chk("m_penable", 32'(PENABLE), 32'(e_pen));
        chk("m_ready", 32'(ready), 32'(e_ready));
        chk("m_error", 32'(error), 32'(e_err));
        chk("m_rdata", rdata, e_rd);
        chk("m_paddr", PADDR, m_addr);
        chk("m_pwdata", PWDATA, m_wdata);
        chk("m_pwrite", 32'(PWRITE), 32'(m_write));
        if (!PRESET) begin
            if (!m_busy || e_ready) begin
                m_busy = transfer;
                if (transfer) begin
                    m_addr = addr; m_wdata = wdata;
                    m_write = write; m_phase = 0;
                end
            end else begin
                m_phase++;
            end
        end
    end

    task automatic tick;
        @(posedge PCLK);
        #2;
    endtask

    task automatic start(input logic [31:0] a, input logic [31:0] d,
                         input logic w);
        addr = a; wdata = d; write = w; transfer = 1'b1;
        tick();
        transfer = 1'b0;
    endtask

    task automatic wait_ready(input string nm, input int lim, output int cyc);
        logic found;
        found = 1'b0;
        cyc = 0;
        for (int i = 1; i <= lim && !found; i++) begin
            @(negedge PCLK);
            if (ready) begin
                found = 1'b1;
                cyc = i;
            end else begin
                tick();
            end
        end
        chk(nm, 32'(found), 32'd1);
    endtask

    initial begin
        int c, ns, np, rc, re;
        wait_cfg = '{0, 0, 1, 3, 255};
        prdata_v = '{32'hDEAD_0000, 32'h0000_00C3, 32'hDEAD_0002,
                     32'hDEAD_0003, 32'hDEAD_0004};
        // Requests during reset are ignored
        transfer = 1'b1; addr = 32'h1000_1004;
        repeat (3) tick();
        @(negedge PCLK);
        chk("rst_paddr", PADDR, 32'h0);
        chk("rst_psel", 32'(psel_v), 32'h0);
        chk("rst_ready", 32'(ready), 32'h0);
        transfer = 1'b0;
        tick();
        PRESET = 1'b0;
        tick();

        // Zero-wait read
        start(32'h1000_1004, 32'h0, 1'b0);
        @(negedge PCLK);
        chk("rd_setup_psel1", 32'(PSEL1), 32'd1);
        chk("rd_setup_pen", 32'(PENABLE), 32'd0);
        tick();
        @(negedge PCLK);
        chk("rd_ready", 32'(ready), 32'd1);
        chk("rd_rdata", rdata, 32'h0000_00C3);
        chk("rd_pwrite", 32'(PWRITE), 32'd0);
        chk("rd_error", 32'(error), 32'd0);
        tick();

        // One-wait write
        start(32'h1000_2008, 32'hA5, 1'b1);
        ns = 0; np = 0; rc = -1; re = -1;
        for (int k = 0; k < 5; k++) begin
            @(negedge PCLK);
            if (PSEL2) ns++;
            if (PENABLE) begin
                np++;
                if (ready) begin rc = np; re = int'(error); end
            end
            tick();
        end
        chk("wr_psel2_cycles", 32'(ns), 32'd3);
        chk("wr_pen_cycles", 32'(np), 32'd2);
        chk("wr_ready_cycle", 32'(rc), 32'd2);
        chk("wr_error", 32'(re), 32'd0);

        // Back-to-back, new addr presented during setup is ignored
        addr = 32'h1000_0000; write = 1'b0; transfer = 1'b1;
        tick();
        addr = 32'h1000_3000;
        @(negedge PCLK);
        chk("b2b_psel0", 32'(PSEL0), 32'd1);
        chk("b2b_paddr0", PADDR, 32'h1000_0000);
        tick();
        @(negedge PCLK);
        chk("b2b_ready0", 32'(ready), 32'd1);
        tick();
        transfer = 1'b0;
        @(negedge PCLK);
        chk("b2b_psel3", 32'(psel_v), 32'h8);
        chk("b2b_setup3", 32'(PENABLE), 32'd0);
        tick();
        wait_ready("b2b3_bound", 10, c);
        chk("b2b3_cycles", 32'(c), 32'd4);
        tick();

        // Unmapped pages, far and just past the map
        start(32'h2000_0000, 32'h55, 1'b1);
        @(negedge PCLK);
        chk("um_psel", 32'(psel_v), 32'h0);
        tick();
        @(negedge PCLK);
        chk("um_ready", 32'(ready), 32'd1);
        chk("um_error", 32'(error), 32'd1);
        tick();
        start(32'h1000_5000, 32'h0, 1'b0);
        tick();
        @(negedge PCLK);
        chk("um5_error", 32'(error), 32'd1);
        chk("um5_rdata", rdata, 32'h0);
        tick();

        // One-wait read at top of page 2
        start(32'h1000_2FFC, 32'h0, 1'b0);
        tick();
        wait_ready("rd2_bound", 10, c);
        chk("rd2_cycles", 32'(c), 32'd2);
        chk("rd2_rdata", rdata, 32'hDEAD_0002);
        tick();

        // Timeout on stuck slave 4
        start(32'h1000_4000, 32'h77, 1'b1);
        tick();
        wait_ready("to_bound", 10, c);
        chk("to_cycles", 32'(c), 32'(TO));
        chk("to_error", 32'(error), 32'd1);
        tick();
        @(negedge PCLK);
        chk("to_idle_pen", 32'(PENABLE), 32'd0);
        chk("to_idle_psel", 32'(psel_v), 32'h0);
        tick();

        // Reset mid-access
        start(32'h1000_3000, 32'h11, 1'b0);
        tick();
        #1 PRESET = 1'b1;
        #1;
        chk("ar_psel", 32'(psel_v), 32'h0);
        chk("ar_pen", 32'(PENABLE), 32'd0);
        chk("ar_ready", 32'(ready), 32'd0);
        tick();
        PRESET = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge PCLK);
            chk("ar_no_ready", 32'(ready), 32'd0);
            tick();
        end
        start(32'h1000_3000, 32'h0, 1'b0);
        tick();
        wait_ready("ar_next_bound", 10, c);
        chk("ar_next_cycles", 32'(c), 32'd4);
        chk("ar_next_rdata", rdata, 32'hDEAD_0003);
        tick();
        repeat (2) tick();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not end, expected $finish");
        $fatal(1);
    end

endmodule
